// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX-stage operand muxes and alu_seq.
// The pipeline side uses master; the ALU uses slave.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       alu_op;
  logic [1:0]       shift_type;
  logic [SHW-1:0]   shift_amt;
  logic             alu_invert_operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero_flag;
  logic             negative_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic             div_by_zero;

  modport master (
    output in_valid, operand1, operand2, alu_op, shift_type, shift_amt,
           alu_invert_operand2, out_ready,
    input  in_ready, out_valid, alu_result, zero_flag, negative_flag,
           carry_flag, overflow_flag, div_by_zero
  );

  modport slave (
    input  in_valid, operand1, operand2, alu_op, shift_type, shift_amt,
           alu_invert_operand2, out_ready,
    output in_ready, out_valid, alu_result, zero_flag, negative_flag,
           carry_flag, overflow_flag, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: 1-cycle ops, WIDTH+1-cycle restoring DIV/MOD.
// Outputs hold while out_valid && !out_ready; in_ready drops during a divide or a stalled result.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave alu
);
  localparam int MSB = WIDTH - 1;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                         OP_MOD = 4'h4, OP_AND = 4'h5, OP_ORR = 4'h6, OP_XOR = 4'h7,
                         OP_BIC = 4'h8, OP_MVN = 4'h9, OP_CMP = 4'hA, OP_TST = 4'hB,
                         OP_MVI = 4'hC;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW:0]     W_SH    = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]     CNT_ONE = (SHW+1)'(1);

  typedef enum logic {IDLE, DIV_RUN} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] op2i, op2s, a, b, prod;
  logic [SHW:0]     rot_amt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res, sc_int;
  logic             sc_c, sc_v, sc_dbz, sc_noflag;
  logic             in_ready, accept, div_start, last_step, is_div_op, b_zero;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [SHW:0]     cnt_q;
  logic             q_neg_q, r_neg_q, is_mod_q, ovf_q;
  logic [WIDTH:0]   trial, trial_sub;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, div_res;

  logic [WIDTH-1:0] res_q;
  logic             vld_q, n_q, z_q, c_q, v_q, dbz_q;

  // Operand2 path: optional invert, then barrel shift; ROR by 0 degenerates to x|0.
  always_comb begin
    op2i    = alu.alu_invert_operand2 ? ~alu.operand2 : alu.operand2;
    rot_amt = W_SH - {1'b0, alu.shift_amt};
    op2s    = op2i;
    case (alu.shift_type)
      2'b00:   op2s = op2i << alu.shift_amt;
      2'b01:   op2s = op2i >> alu.shift_amt;
      2'b10:   op2s = $unsigned($signed(op2i) >>> alu.shift_amt);
      default: op2s = (op2i >> alu.shift_amt) | (op2i << rot_amt);
    endcase
  end

  assign a         = alu.operand1;
  assign b         = op2s;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign prod      = a * b;
  assign is_div_op = (alu.alu_op == OP_DIV) || (alu.alu_op == OP_MOD);
  assign b_zero    = (b == '0);

  // Single-cycle results; sc_int is what N/Z look at (differs from sc_res for CMP/TST).
  always_comb begin
    sc_res    = '0;
    sc_int    = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_dbz    = 1'b0;
    sc_noflag = 1'b0;
    case (alu.alu_op)
      OP_ADD: begin
        sc_int = sum[MSB:0];
        sc_res = sum[MSB:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        sc_int = diff[MSB:0];
        sc_res = (alu.alu_op == OP_SUB) ? diff[MSB:0] : '0;
        sc_c   = ~diff[WIDTH];
        sc_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_MUL: begin sc_int = prod;    sc_res = prod;    end
      OP_AND: begin sc_int = a & b;   sc_res = a & b;   end
      OP_ORR: begin sc_int = a | b;   sc_res = a | b;   end
      OP_XOR: begin sc_int = a ^ b;   sc_res = a ^ b;   end
      OP_BIC: begin sc_int = a & ~b;  sc_res = a & ~b;  end
      OP_MVN: begin sc_int = ~b;      sc_res = ~b;      end
      OP_TST: begin sc_int = a & b;   sc_res = '0;      end
      OP_MVI: begin sc_int = b;       sc_res = b;       end
      OP_DIV, OP_MOD: begin
        sc_res    = '1;
        sc_dbz    = 1'b1;
        sc_noflag = 1'b1;
      end
      default: sc_noflag = 1'b1;
    endcase
  end

  // One restoring step on the magnitudes; the last step feeds the output register directly.
  always_comb begin
    trial     = {rem_q, quo_q[MSB]};
    trial_sub = trial - {1'b0, dvs_q};
    trial_ge  = ~trial_sub[WIDTH];
    rem_nxt   = trial_ge ? trial_sub[MSB:0] : trial[MSB:0];
    quo_nxt   = {quo_q[MSB-1:0], trial_ge};
    if (is_mod_q) div_res = r_neg_q ? -rem_nxt : rem_nxt;
    else          div_res = q_neg_q ? -quo_nxt : quo_nxt;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE) && (!vld_q || alu.out_ready);
    accept    = alu.in_valid && in_ready;
    div_start = accept && is_div_op && !b_zero;
    last_step = (state_q == DIV_RUN) && (cnt_q == CNT_ONE);
    case (state_q)
      IDLE:    if (div_start) state_d = DIV_RUN;
      DIV_RUN: if (last_step) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      res_q    <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      dbz_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_mod_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (vld_q && alu.out_ready) vld_q <= 1'b0;

      if (accept && !div_start) begin
        vld_q <= 1'b1;
        res_q <= sc_res;
        n_q   <= sc_noflag ? 1'b0 : sc_int[MSB];
        z_q   <= sc_noflag ? 1'b0 : (sc_int == '0);
        c_q   <= sc_c;
        v_q   <= sc_v;
        dbz_q <= sc_dbz;
      end

      if (div_start) begin
        rem_q    <= '0;
        quo_q    <= a[MSB] ? -a : a;
        dvs_q    <= b[MSB] ? -b : b;
        cnt_q    <= W_SH;
        q_neg_q  <= a[MSB] ^ b[MSB];
        r_neg_q  <= a[MSB];
        is_mod_q <= (alu.alu_op == OP_MOD);
        ovf_q    <= (a == MIN_VAL) && (b == '1);
      end

      if (state_q == DIV_RUN) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CNT_ONE;
        if (last_step) begin
          vld_q <= 1'b1;
          res_q <= div_res;
          n_q   <= div_res[MSB];
          z_q   <= (div_res == '0);
          c_q   <= 1'b0;
          v_q   <= ovf_q;
          dbz_q <= 1'b0;
        end
      end
    end
  end

  assign alu.in_ready      = in_ready;
  assign alu.out_valid     = vld_q;
  assign alu.alu_result    = res_q;
  assign alu.negative_flag = n_q;
  assign alu.zero_flag     = z_q;
  assign alu.carry_flag    = c_q;
  assign alu.overflow_flag = v_q;
  assign alu.div_by_zero   = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(16)) bus16 ();
  alu_seq_if #(.WIDTH(64)) bus64 ();
  alu_seq #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .alu(bus));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .alu(bus16));
  alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .alu(bus64));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res;
  logic [4:0]  last_flg;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {bus.negative_flag, bus.zero_flag, bus.carry_flag, bus.overflow_flag, bus.div_by_zero};
  endfunction

  // Reference: flags packed as {N,Z,C,V,div_by_zero}.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] op2,
                                input bit inv, input logic [1:0] st, input logic [4:0] sa,
                                output logic [31:0] res, output logic [4:0] flg, output int lat);
    logic [31:0] b, internal;
    longint sa_l, sb_l, s, q, r;
    longint unsigned ua, ub, full;
    bit c, v, dbz, noflags;
    b = inv ? ~op2 : op2;
    case (st)
      2'd0: b = b << sa;
      2'd1: b = b >> sa;
      2'd2: for (int i = 0; i < sa; i++) b = {b[31], b[31:1]};
      default: for (int i = 0; i < sa; i++) b = {b[0], b[31:1]};
    endcase
    ua = a; ub = b; sa_l = $signed(a); sb_l = $signed(b);
    lat = 1; res = '0; internal = '0; c = 0; v = 0; dbz = 0; noflags = 0;
    case (op)
      4'h0: begin
        full = ua + ub; internal = full[31:0]; res = internal;
        c = (full >= 64'h1_0000_0000);
        s = sa_l + sb_l; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1, 4'hA: begin
        internal = a - b; res = (op == 4'h1) ? internal : '0;
        c = (ua >= ub);
        s = sa_l - sb_l; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: begin full = ua * ub; internal = full[31:0]; res = internal; end
      4'h3, 4'h4: begin
        if (b == 0) begin
          res = '1; dbz = 1; noflags = 1;
        end else begin
          lat = 33;
          if (a == MIN32 && b == 32'hFFFF_FFFF) begin q = sa_l; r = 0; v = 1; end
          else begin q = sa_l / sb_l; r = sa_l % sb_l; end
          internal = (op == 4'h3) ? q[31:0] : r[31:0];
          res = internal;
        end
      end
      4'h5: begin internal = a & b;  res = internal; end
      4'h6: begin internal = a | b;  res = internal; end
      4'h7: begin internal = a ^ b;  res = internal; end
      4'h8: begin internal = a & ~b; res = internal; end
      4'h9: begin internal = ~b;     res = internal; end
      4'hB: begin internal = a & b;  res = '0;       end
      4'hC: begin internal = b;      res = internal; end
      default: noflags = 1;
    endcase
    flg = noflags ? {4'b0, dbz} : {internal[31], internal == 0, c, v, dbz};
  endfunction

  // One op: accept, measure latency, compare; hold>0 stalls out_ready; keep leaves it stalled.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inv, input logic [1:0] st, input logic [4:0] sa,
                        input int hold, input bit keep);
    logic [31:0] er; logic [4:0] ef; int el, w, lat;
    model(op, a, b, inv, st, sa, er, ef, el);
    @(posedge clk); #1;
    bus.alu_op = op; bus.operand1 = a; bus.operand2 = b; bus.alu_invert_operand2 = inv;
    bus.shift_type = st; bus.shift_amt = sa; bus.out_ready = (hold == 0); bus.in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      chk({tag, "_rdy_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (el > 1 && lat == 2) chk({tag, "_busy_rdy"}, bus.in_ready, 0);
      if (bus.out_valid) break;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, bus.alu_result, er);
    chk({tag, "_flg"}, dut_flags(), ef);
    last_res = bus.alu_result; last_flg = dut_flags();
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_hold_res"}, {bus.out_valid, bus.alu_result}, {1'b1, er});
      chk({tag, "_hold_rdy"}, bus.in_ready, 0);
      if (!keep) begin bus.out_ready = 1'b1; @(posedge clk); #1; end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return MIN32;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    bus.in_valid = 0; bus.operand1 = 0; bus.operand2 = 0; bus.alu_op = 0; bus.shift_type = 0;
    bus.shift_amt = 0; bus.alu_invert_operand2 = 0; bus.out_ready = 1;
    bus16.in_valid = 0; bus16.operand1 = 0; bus16.operand2 = 0; bus16.alu_op = 0; bus16.shift_type = 0;
    bus16.shift_amt = 0; bus16.alu_invert_operand2 = 0; bus16.out_ready = 1;
    bus64.in_valid = 0; bus64.operand1 = 0; bus64.operand2 = 0; bus64.alu_op = 0; bus64.shift_type = 0;
    bus64.shift_amt = 0; bus64.alu_invert_operand2 = 0; bus64.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_res", bus.alu_result, 0);
    chk("rst_flg", dut_flags(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", bus.in_ready, 1);

    run_op("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'h1, 0, 2'd0, 5'd0, 0, 0);
    chk("add_ovf_k", {last_res, last_flg}, {32'h8000_0000, 5'b10010});

    // SUB then CMP on consecutive cycles
    @(posedge clk); #1;
    bus.out_ready = 1; bus.alu_op = 4'h1; bus.operand1 = 5; bus.operand2 = 5;
    bus.shift_type = 0; bus.shift_amt = 0; bus.alu_invert_operand2 = 0; bus.in_valid = 1;
    @(negedge clk);
    chk("b2b_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.alu_op = 4'hA; bus.operand1 = 3; bus.operand2 = 7;
    @(negedge clk);
    chk("b2b_sub", {bus.out_valid, bus.alu_result, dut_flags()}, {1'b1, 32'h0, 5'b01100});
    chk("b2b_rdy2", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 0;
    @(negedge clk);
    chk("b2b_cmp", {bus.out_valid, bus.alu_result, dut_flags()}, {1'b1, 32'h0, 5'b10000});

    run_op("div_m7", 4'h3, 32'hFFFF_FFF9, 32'h2, 0, 2'd0, 5'd0, 0, 0);
    chk("div_m7_k", last_res, 32'hFFFF_FFFD);
    run_op("mod_m7", 4'h4, 32'hFFFF_FFF9, 32'h2, 0, 2'd0, 5'd0, 0, 0);
    chk("mod_m7_k", last_res, 32'hFFFF_FFFF);
    run_op("div0", 4'h3, 32'd10, 32'h0, 0, 2'd0, 5'd0, 0, 0);
    chk("div0_k", {last_res, last_flg}, {32'hFFFF_FFFF, 5'b00001});
    run_op("div_ovf", 4'h3, MIN32, 32'hFFFF_FFFF, 0, 2'd0, 5'd0, 0, 0);
    chk("div_ovf_k", {last_res, last_flg}, {MIN32, 5'b10010});
    run_op("ror8", 4'hC, 32'h0, 32'h1234_5678, 0, 2'd3, 5'd8, 0, 0);
    chk("ror8_k", last_res, 32'h7812_3456);

    // Drain and accept in the same cycle
    run_op("orr_bp", 4'h6, 32'hF0, 32'h0F, 0, 2'd0, 5'd0, 3, 1);
    @(posedge clk); #1;
    bus.alu_op = 4'h0; bus.operand1 = 1; bus.operand2 = 1; bus.in_valid = 1; bus.out_ready = 1;
    @(negedge clk);
    chk("drain_rdy", bus.in_ready, 1);
    chk("drain_old", {bus.out_valid, bus.alu_result}, {1'b1, 32'hFF});
    @(posedge clk); #1 bus.in_valid = 0;
    @(negedge clk);
    chk("drain_new", {bus.out_valid, bus.alu_result}, {1'b1, 32'h2});

    // Reset during a divide discards it
    @(posedge clk); #1;
    bus.alu_op = 4'h3; bus.operand1 = 100; bus.operand2 = 7; bus.in_valid = 1;
    @(negedge clk);
    @(posedge clk); #1 bus.in_valid = 0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst", {bus.out_valid, bus.alu_result, dut_flags(), bus.in_ready}, {1'b0, 32'h0, 5'b0, 1'b1});
    vcount = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) vcount++; end
    chk("mid_rst_stray", vcount, 0);
    run_op("post_rst_add", 4'h0, 32'd2, 32'd3, 0, 2'd0, 5'd0, 0, 0);
    chk("post_rst_add_k", last_res, 32'd5);

    // ROR 8 at other widths
    @(posedge clk); #1;
    bus16.alu_op = 4'hC; bus16.operand2 = 16'h5678; bus16.shift_type = 2'd3; bus16.shift_amt = 4'd8;
    bus64.alu_op = 4'hC; bus64.operand2 = 64'h1234_5678; bus64.shift_type = 2'd3; bus64.shift_amt = 6'd8;
    bus16.in_valid = 1; bus64.in_valid = 1;
    @(negedge clk);
    chk("w_rdy", {bus16.in_ready, bus64.in_ready}, 2'b11);
    @(posedge clk); #1 bus16.in_valid = 0; bus64.in_valid = 0;
    @(negedge clk);
    chk("w16_ror", {bus16.out_valid, bus16.alu_result}, {1'b1, 16'h7856});
    chk("w64_ror", {bus64.out_valid, bus64.alu_result}, {1'b1, 64'h7800_0000_0012_3456});

    for (int i = 0; i < 200; i++) begin
      logic [3:0] op; logic [4:0] sa; int hold;
      op   = 4'($urandom_range(0, 15));
      sa   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_op("rnd", op, pick(), pick(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), sa, hold, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
